// File: rtl/ast_width_ext.sv
// Avalon-ST width up-converter: packs consecutive narrow beats of one packet
// into a single wide output word, carrying sop/eop/channel/empty through.
module ast_width_ext #(
    parameter int DATA_IN_W   = 64,
    parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 256,
    parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,

    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,

    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int              RATIO    = DATA_OUT_W / DATA_IN_W;
    localparam int              KW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int              BYTES_IN = DATA_IN_W / 8;
    localparam logic [KW-1:0]   K_LAST   = KW'(RATIO - 1);

    // Assembly state
    logic [DATA_OUT_W-1:0]  asm_q, asm_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   in_pkt_q, in_pkt_d;
    logic                   first_q, first_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;

    // Output register
    logic                   valid_q, valid_d;
    logic [DATA_OUT_W-1:0]  data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
    logic [CHANNEL_W-1:0]   chan_o_q, chan_o_d;

    // Per-beat working values
    logic                   in_xfer;
    logic                   take;
    logic                   done;
    logic [KW-1:0]          k_eff;
    logic [DATA_OUT_W-1:0]  word;
    logic [CHANNEL_W-1:0]   chan_eff;
    logic                   first_eff;
    logic [EMPTY_OUT_W-1:0] empty_calc;

    assign ast_ready_o = !valid_q || ast_ready_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        in_xfer    = ast_valid_i && ast_ready_o;
        take       = in_xfer && (ast_startofpacket_i || in_pkt_q);
        k_eff      = ast_startofpacket_i ? '0 : k_q;
        chan_eff   = ast_startofpacket_i ? ast_channel_i : chan_q;
        first_eff  = ast_startofpacket_i || first_q;
        word       = ast_startofpacket_i ? '0 : asm_q;
        for (int i = 0; i < RATIO; i++) begin
            if (k_eff == KW'(i)) begin
                word[i*DATA_IN_W +: DATA_IN_W] = ast_data_i;
            end
        end
        done       = take && ((k_eff == K_LAST) || ast_endofpacket_i);
        empty_calc = ast_endofpacket_i
                   ? EMPTY_OUT_W'(int'(K_LAST - k_eff) * BYTES_IN + int'(ast_empty_i))
                   : '0;

        asm_d    = asm_q;
        k_d      = k_q;
        in_pkt_d = in_pkt_q;
        first_d  = first_q;
        chan_d   = chan_q;
        if (take) begin
            chan_d = chan_eff;
            if (done) begin
                asm_d    = '0;
                k_d      = '0;
                first_d  = 1'b0;
                in_pkt_d = !ast_endofpacket_i;
            end else begin
                asm_d    = word;
                k_d      = k_eff + KW'(1);
                first_d  = first_eff;
                in_pkt_d = 1'b1;
            end
        end
    end

    // A completed word lands in the output register on the accepting edge;
    // the handshake on ast_ready_o guarantees the register is free by then.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        empty_d  = empty_q;
        chan_o_d = chan_o_q;
        if (done) begin
            valid_d  = 1'b1;
            data_d   = word;
            sop_d    = first_eff;
            eop_d    = ast_endofpacket_i;
            empty_d  = empty_calc;
            chan_o_d = chan_eff;
        end else if (ast_ready_i) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (srst_i) begin
            asm_q    <= '0;
            k_q      <= '0;
            in_pkt_q <= 1'b0;
            first_q  <= 1'b0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            empty_q  <= '0;
            chan_o_q <= '0;
        end else begin
            asm_q    <= asm_d;
            k_q      <= k_d;
            in_pkt_q <= in_pkt_d;
            first_q  <= first_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            empty_q  <= empty_d;
            chan_o_q <= chan_o_d;
        end
    end

    assign ast_valid_o         = valid_q;
    assign ast_data_o          = data_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = chan_o_q;

endmodule

// File: tb/tb_ast_width_ext.sv
// Randomized bench for ast_width_ext: a beat-level packing model feeds a
// scoreboard of expected output words, plus handshake and hold checks.
module tb_ast_width_ext;

    localparam int DIN = 64;
    localparam int DOUT = 256;
    localparam int CHW = 10;
    localparam int EIW = 3;
    localparam int EOW = 5;
    localparam int R = DOUT / DIN;

    logic            clk = 1'b0;
    logic            srst_i = 1'b1;
    logic [DIN-1:0]  ast_data_i = '0;
    logic            ast_startofpacket_i = 1'b0;
    logic            ast_endofpacket_i = 1'b0;
    logic            ast_valid_i = 1'b0;
    logic [EIW-1:0]  ast_empty_i = '0;
    logic [CHW-1:0]  ast_channel_i = '0;
    logic            ast_ready_o;
    logic [DOUT-1:0] ast_data_o;
    logic            ast_startofpacket_o;
    logic            ast_endofpacket_o;
    logic            ast_valid_o;
    logic [EOW-1:0]  ast_empty_o;
    logic [CHW-1:0]  ast_channel_o;
    logic            ast_ready_i = 1'b1;

    always #5 clk = ~clk;

    ast_width_ext #(
        .DATA_IN_W(DIN), .EMPTY_IN_W(EIW), .CHANNEL_W(CHW),
        .DATA_OUT_W(DOUT), .EMPTY_OUT_W(EOW)
    ) dut (
        .clk_i(clk), .srst_i(srst_i),
        .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
        .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
        .ast_ready_o(ast_ready_o),
        .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
        .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
        .ast_ready_i(ast_ready_i)
    );

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic            sop;
        logic            eop;
        logic [EOW-1:0]  empty;
        logic [CHW-1:0]  ch;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Reference packing model state
    bit              m_in_pkt = 0;
    bit              m_first = 0;
    int              m_nb = 0;
    logic [DOUT-1:0] m_word = '0;
    logic [CHW-1:0]  m_ch = '0;

    bit    started = 0;
    bit    exp_valid = 0;
    bit    prev_stall = 0;
    word_t prev_out;
    word_t last_out = '0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    always @(negedge clk) begin
        word_t cur;
        word_t w;
        bit    emitted;
        cur = {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
        emitted = 0;
        if (started) begin
            check("valid", ast_valid_o, exp_valid);
            check("ready_o", ast_ready_o, !ast_valid_o || ast_ready_i);
            if (prev_stall) check("hold", cur, prev_out);
        end
        if (srst_i) begin
            m_in_pkt = 0; m_first = 0; m_nb = 0; m_word = '0;
            exp_q.delete();
            exp_valid = 0;
            prev_stall = 0;
        end else begin
            if (ast_valid_o && ast_ready_i) begin
                if (exp_q.size() == 0) check("spurious_word", 1, 0);
                else check("word", cur, exp_q.pop_front());
                last_out = cur;
            end
            if (ast_valid_i && ast_ready_o) begin
                if (ast_startofpacket_i) begin
                    m_in_pkt = 1; m_first = 1; m_nb = 0; m_word = '0; m_ch = ast_channel_i;
                end
                if (m_in_pkt) begin
                    m_word[m_nb*DIN +: DIN] = ast_data_i;
                    m_nb++;
                    if (m_nb == R || ast_endofpacket_i) begin
                        w.data  = m_word;
                        w.sop   = m_first;
                        w.eop   = ast_endofpacket_i;
                        w.empty = ast_endofpacket_i ? EOW'((R - m_nb) * (DIN / 8) + int'(ast_empty_i)) : '0;
                        w.ch    = m_ch;
                        exp_q.push_back(w);
                        emitted = 1;
                        m_word = '0; m_nb = 0; m_first = 0;
                        if (ast_endofpacket_i) m_in_pkt = 0;
                    end
                end
            end
            exp_valid  = emitted || (ast_valid_o && !ast_ready_i);
            prev_stall = ast_valid_o && !ast_ready_i;
            prev_out   = cur;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       ast_ready_i = 1'b1;
                1:       ast_ready_i = 1'($urandom % 2);
                default: ast_ready_i = 1'b0;
            endcase
        end
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [DIN-1:0] d, input bit sop, input bit eop,
                             input logic [EIW-1:0] emp, input logic [CHW-1:0] ch);
        int waits = 0;
        bit acc;
        ast_data_i = d; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
        ast_empty_i = emp; ast_channel_i = ch; ast_valid_i = 1'b1;
        do begin
            @(negedge clk); acc = ast_ready_o;
            @(posedge clk); #1; waits++;
        end while (!acc && waits < 1000);
        if (!acc) check("accept_timeout", 0, 1);
        ast_valid_i = 1'b0;
    endtask

    function automatic logic [DIN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_pkt(input int len, input logic [CHW-1:0] ch, input logic [EIW-1:0] emp,
                            input bit vary_ch, input bit gaps);
        for (int i = 0; i < len; i++) begin
            send_beat(rnd64(), i == 0, i == len - 1, (i == len - 1) ? emp : EIW'($urandom),
                      (vary_ch && i != 0) ? CHW'($urandom) : ch);
            if (gaps && ($urandom % 4 == 0)) idle(1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || ast_valid_o) && n < 500) begin idle(1); n++; end
        if (n >= 500) check("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [DIN-1:0] d[4];
        word_t          w;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", ast_valid_o, 0);
        check("rst_sop", ast_startofpacket_o, 0);
        check("rst_eop", ast_endofpacket_o, 0);
        check("rst_data", ast_data_o, 0);
        check("rst_empty", ast_empty_o, 0);
        check("rst_channel", ast_channel_o, 0);
        @(posedge clk); #1;
        srst_i = 1'b0;
        started = 1;
        idle(2);

        // Single full packet on channel 5
        for (int i = 0; i < 4; i++) d[i] = rnd64();
        for (int i = 0; i < 4; i++) send_beat(d[i], i == 0, i == 3, 3'd0, 10'd5);
        @(negedge clk);
        check("d4_valid_latency", ast_valid_o, 1);
        @(posedge clk); #1;
        wait_drain();
        w = {d[3], d[2], d[1], d[0], 1'b1, 1'b1, 5'd0, 10'd5};
        check("d4_word", last_out, w);

        // Lengths 1..12 with empty_i=3 on the last beat
        for (int len = 1; len <= 12; len++) begin
            send_pkt(len, CHW'(len), 3'd3, 0, 0);
            wait_drain();
            if (len == 1) begin
                check("len1_empty", last_out.empty, 27);
                check("len1_upper_zero", last_out.data[DOUT-1:DIN], 0);
            end
            if (len == 6) check("len6_empty", last_out.empty, 19);
        end

        // Random packets with random backpressure
        ready_mode = 1;
        for (int p = 0; p < 100; p++) begin
            send_pkt(1 + int'($urandom % 12), CHW'($urandom), EIW'($urandom), 1, 1);
        end
        wait_drain();
        ready_mode = 0;
        idle(2);

        // Stray beats, then a packet abandoned by a new sop
        send_beat(rnd64(), 0, 0, 3'd0, 10'd1);
        send_beat(rnd64(), 0, 1, 3'd2, 10'd1);
        for (int i = 0; i < 5; i++) send_beat(rnd64(), i == 0, 0, 3'd0, 10'd2);
        send_pkt(3, 10'd11, 3'd1, 0, 0);
        wait_drain();
        check("abandon_channel", last_out.ch, 11);
        check("abandon_sop_eop", {last_out.sop, last_out.eop}, 2'b11);

        // Channel ignored on non-sop beats
        send_beat(rnd64(), 1, 0, 3'd0, 10'd7);
        send_beat(rnd64(), 0, 0, 3'd0, 10'd9);
        send_beat(rnd64(), 0, 0, 3'd0, 10'd3);
        send_beat(rnd64(), 0, 0, 3'd0, 10'd9);
        send_beat(rnd64(), 0, 1, 3'd0, 10'd3);
        wait_drain();
        check("chan_hold", last_out.ch, 7);

        // Reset while a word is pending under backpressure
        ready_mode = 2;
        idle(2);
        send_pkt(4, 10'd8, 3'd0, 0, 0);
        idle(1);
        srst_i = 1'b1;
        idle(1);
        srst_i = 1'b0;
        @(negedge clk);
        check("srst_valid", ast_valid_o, 0);
        @(posedge clk); #1;
        ready_mode = 0;
        idle(1);
        d[0] = rnd64();
        send_beat(d[0], 1, 1, 3'd0, 10'd4);
        wait_drain();
        check("post_rst_lane0", last_out.data, {{(DOUT-DIN){1'b0}}, d[0]});
        check("post_rst_empty", last_out.empty, 24);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ast_width_ext.md
Name: ast_width_ext

Overview:
Avalon-ST width up-converter. It packs consecutive narrow input beats of one packet into a single wide output word, and passes packet framing, channel and empty information through. The block sits between a narrow AST source (64-bit) and a wide AST sink (256-bit). It applies backpressure through ast_ready_o.

Parameters:
DATA_IN_W, 64, input data width in bits; multiple of 8.
EMPTY_IN_W, clog2(DATA_IN_W/8) (min 1), input empty width.
CHANNEL_W, 10, channel width.
DATA_OUT_W, 256, output data width; integer multiple of DATA_IN_W (RATIO = DATA_OUT_W/DATA_IN_W, ≥1).
EMPTY_OUT_W, clog2(DATA_OUT_W/8) (min 1), output empty width.

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
ast_data_i  in  DATA_IN_W  input data
ast_startofpacket_i  in  1  first beat of packet
ast_endofpacket_i  in  1  last beat of packet
ast_valid_i  in  1  input beat valid
ast_empty_i  in  EMPTY_IN_W  unused bytes in eop beat
ast_channel_i  in  CHANNEL_W  packet channel
ast_ready_o  out  1  block accepts input beat
ast_data_o  out  DATA_OUT_W  packed data
ast_startofpacket_o  out  1  first word of packet
ast_endofpacket_o  out  1  last word of packet
ast_valid_o  out  1  output word valid
ast_empty_o  out  EMPTY_OUT_W  unused bytes in eop word
ast_channel_o  out  CHANNEL_W  packet channel
ast_ready_i  in  1  sink accepts word

Behaviour:
- One clock; reset is synchronous and active-high: clk_i, srst_i.
- Reset state: ast_valid_o=0, sop_o=0, eop_o=0, data_o=0, empty_o=0, channel_o=0. Beat index=0, no packet in progress. Reset mid-packet discards the partial word and any pending output.
- Input transfer occurs when ast_valid_i & ast_ready_o. Output transfer occurs when ast_valid_o & ast_ready_i.
- ast_ready_o = !ast_valid_o | ast_ready_i. It is combinational and never depends on ast_valid_i.
- Assembly buffer plus beat index k (0..RATIO-1). Accepted beat k is written to data bits [k*DATA_IN_W +: DATA_IN_W]. The first beat goes to the LSBs. Lanes not written in a word are 0.
- Accepted beat with sop: k restarts at 0, the buffer is cleared, channel is latched, and the word's sop flag is set. If a packet was in progress, its partial word is silently dropped.
- Accepted beat without sop while no packet is in progress: the beat is discarded.
- Word completion: a word completes on the beat with k=RATIO-1 or on an eop beat. The completed word loads the output register the next cycle, so latency is 1 cycle from the accepting edge. ast_valid_o is set, and data, sop, eop and channel are set from the word. k is then reset to 0.
- ast_empty_o = (RATIO-1-k)*(DATA_IN_W/8) + ast_empty_i when eop is set, otherwise 0.
- Channel: every word of a packet carries the channel latched at sop. Channel values on non-sop beats are ignored.
- A single-beat packet (sop & eop) produces one word with sop=1 and eop=1.
- The output register holds while ast_ready_i=0. Output is stable until consumed.
- Outputs other than ast_valid_o are don't-care when ast_valid_o=0, but must keep their last value.
- Back-to-back packets run at full throughput: no idle cycle is required between eop and the next sop.

Test Plan:
- Reset, then one 4-beat packet on channel 5, beats D0..D3, empty_i=0, ast_ready_i=1 -> one word {D3,D2,D1,D0}, sop=1, eop=1, empty=0, channel=5, valid exactly 1 cycle after beat D3 is accepted.
- Packet lengths 1..12 beats, empty_i=3 on the eop beat -> ceil(len/4) words. eop word empty=(3-k)*8+3, e.g. len=1 gives empty=27 with data in bits[63:0] and zeros above; len=6 gives 2 words, second empty=19.
- Random ast_ready_i (~50%) over 100 random packets -> no data lost or duplicated. Output stays stable while stalled. ast_ready_o=0 exactly when ast_valid_o=1 and ast_ready_i=0.
- Beats before any sop, plus a sop arriving mid-packet -> stray beats are dropped and the partial packet is abandoned. The new packet is output correctly with its own channel.
- Channel changes on non-sop beats (7 at sop, then 9, 3) -> all words of the packet report channel 7.
- srst_i asserted while a word is pending and ast_ready_i=0 -> the next cycle ast_valid_o=0, and the following packet is packed starting at lane 0.
